to_lower_stream: RTL and testbench

TO_LOWER_STREAM -- requirements
Module: to_lower_stream

---
 rtl/to_lower_stream.sv | 133 +++++++++++++
 tb/tb_to_lower_stream.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/to_lower_stream.sv
// -----------------------------------------------------------------------------
// to_lower_stream
//   Streaming ASCII upper-to-lower case converter with a small circular FIFO
//   and two saturating statistics counters.
//
//   Parameters
//     DEPTH  buffer depth in characters (2, 4, 8 or 16)
//     CNT_W  width of char_count / conv_count
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     in_valid/in_ready   upstream handshake, in_char is the raw byte
//     out_valid/out_ready downstream handshake, out_char is the converted head
//     clr_cnt             synchronous clear of both counters
//     char_count          number of accepted characters (saturating)
//     conv_count          number of accepted characters that were 'A'..'Z'
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both 1. in_ready depends only on registered state, never on out_ready, so
//   a full buffer refuses input even in a cycle where the head is popped.
//   out_valid/out_char depend only on registered state and stay stable while
//   out_valid=1 and out_ready=0.
// -----------------------------------------------------------------------------
module to_lower_stream #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_char,
  input  logic             out_ready,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] char_count,
  output logic [CNT_W-1:0] conv_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Character storage carries no reset; occ_q alone decides what is valid.
  logic [7:0]       mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  // Goes high at the first edge after reset release; holds in_ready low
  // through reset and that first edge.
  logic             init_q, init_d;
  logic [CNT_W-1:0] char_cnt_q, char_cnt_d;
  logic [CNT_W-1:0] conv_cnt_q, conv_cnt_d;

  logic             is_upper;
  logic [7:0]       conv_char;
  logic             accept;
  logic             pop;

  assign is_upper  = (in_char >= 8'h41) && (in_char <= 8'h5A);
  assign conv_char = is_upper ? (in_char | 8'h20) : in_char;

  assign in_ready  = init_q && (occ_q < OCC_FULL);
  assign out_valid = (occ_q != '0);
  assign out_char  = out_valid ? mem_q[rd_ptr_q] : 8'h00;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    init_d     = 1'b1;
    char_cnt_d = char_cnt_q;
    conv_cnt_d = conv_cnt_q;

    if (accept) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end

    // Simultaneous accept and pop leave occupancy unchanged.
    case ({accept, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    // Clear wins over a same-edge accept; counters stick at all-ones.
    if (clr_cnt) begin
      char_cnt_d = '0;
      conv_cnt_d = '0;
    end else if (accept) begin
      if (char_cnt_q != CNT_MAX) char_cnt_d = char_cnt_q + 1'b1;
      if (is_upper && (conv_cnt_q != CNT_MAX)) conv_cnt_d = conv_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      init_q     <= 1'b0;
      char_cnt_q <= '0;
      conv_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      init_q     <= init_d;
      char_cnt_q <= char_cnt_d;
      conv_cnt_q <= conv_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= conv_char;
    end
  end

  assign char_count = char_cnt_q;
  assign conv_count = conv_cnt_q;

endmodule

// File: tb/tb_to_lower_stream.sv
// -----------------------------------------------------------------------------
// tb_to_lower_stream
//   Directed bench for to_lower_stream (DEPTH=4, CNT_W=4) with a reference
//   queue model and a closing random run. Inputs change 1 time unit after the
//   rising edge; everything is observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_to_lower_stream;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [7:0]       in_char;
  logic             in_ready;
  logic             out_valid;
  logic [7:0]       out_char;
  logic             out_ready;
  logic             clr_cnt;
  logic [CNT_W-1:0] char_count;
  logic [CNT_W-1:0] conv_count;

  always #5 clk = ~clk;

  to_lower_stream #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_char    (in_char),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_char   (out_char),
    .out_ready  (out_ready),
    .clr_cnt    (clr_cnt),
    .char_count (char_count),
    .conv_count (conv_count)
  );

  // ---------------- check task ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  logic       m_init = 1'b0;
  int         m_char = 0;
  int         m_conv = 0;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  function automatic logic [7:0] lower_of(input logic [7:0] c);
    if (c >= 8'h41 && c <= 8'h5A) return c + 8'd32;
    return c;
  endfunction

  always @(negedge clk) begin
    logic acc, pp;
    if (!rst_n) begin
      exp_q.delete();
      m_init = 1'b0;
      m_char = 0;
      m_conv = 0;
    end else begin
      chk("mon_out_valid", out_valid, exp_q.size() != 0);
      chk("mon_in_ready", in_ready, m_init && (exp_q.size() < DEPTH));
      chk("mon_out_char", out_char, (exp_q.size() != 0) ? exp_q[0] : 8'h00);
      chk("mon_char_count", char_count, m_char);
      chk("mon_conv_count", conv_count, m_conv);
      acc = in_valid && m_init && (exp_q.size() < DEPTH);
      pp  = (exp_q.size() != 0) && out_ready;
      if (pp) begin
        obs_q.push_back(out_char);
        void'(exp_q.pop_front());
      end
      if (acc) exp_q.push_back(lower_of(in_char));
      if (clr_cnt) begin
        m_char = 0;
        m_conv = 0;
      end else if (acc) begin
        if (m_char < CNT_SAT) m_char++;
        if (in_char >= 8'h41 && in_char <= 8'h5A && m_conv < CNT_SAT) m_conv++;
      end
      m_init = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] c);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_char  = c;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while (out_valid && t < 50) begin
      t++;
      @(negedge clk);
    end
    chk("drain_timeout", out_valid, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  logic [7:0] basic_in  [6] = '{8'h41, 8'h5A, 8'h61, 8'h40, 8'h5B, 8'hC1};
  logic [7:0] basic_exp [6] = '{8'h61, 8'h7A, 8'h61, 8'h40, 8'h5B, 8'hC1};
  logic [7:0] bp_in     [5] = '{8'h41, 8'h62, 8'h43, 8'h37, 8'h5A};
  logic [7:0] bp_exp    [5] = '{8'h61, 8'h62, 8'h63, 8'h37, 8'h7A};

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_char   = 8'h00;
    out_ready = 1'b0;
    clr_cnt   = 1'b0;

    // Reset state
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_char", out_char, 8'h00);
    chk("rst_char_count", char_count, 0);
    chk("rst_conv_count", conv_count, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("init_ready_low", in_ready, 0);
    @(negedge clk);
    chk("init_ready_high", in_ready, 1);
    @(posedge clk);
    #1;

    // Basic conversion with one-cycle latency
    out_ready = 1'b1;
    obs_q.delete();
    foreach (basic_in[i]) begin
      in_valid = 1'b1;
      in_char  = basic_in[i];
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("basic_latency_valid", out_valid, 1);
      chk("basic_latency_char", out_char, basic_exp[i]);
      @(posedge clk);
      #1;
    end
    drain();
    chk("basic_count_obs", obs_q.size(), 6);
    foreach (basic_exp[i]) chk("basic_order", (i < obs_q.size()) ? obs_q[i] : 8'hxx, basic_exp[i]);
    chk("basic_char_count", char_count, 6);
    chk("basic_conv_count", conv_count, 2);

    // Fill and backpressure
    out_ready = 1'b0;
    obs_q.delete();
    for (int i = 0; i < 4; i++) send(bp_in[i]);
    in_valid = 1'b1;
    in_char  = bp_in[4];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_full_ready", in_ready, 0);
      chk("bp_full_valid", out_valid, 1);
      chk("bp_hold_char", out_char, bp_exp[0]);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(bp_in[4]);
    drain();
    chk("bp_count_obs", obs_q.size(), 5);
    foreach (bp_exp[i]) chk("bp_order", (i < obs_q.size()) ? obs_q[i] : 8'hxx, bp_exp[i]);

    // Simultaneous push/pop at occupancy 2
    out_ready = 1'b0;
    obs_q.delete();
    send(8'h30);
    send(8'h31);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_char  = 8'h41 + 8'(i);
      @(negedge clk);
      chk("pp_out_valid", out_valid, 1);
      chk("pp_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("pp_occ2_ready", in_ready, 1);
    chk("pp_occ2_char", out_char, 8'h69);
    drain();
    chk("pp_count_obs", obs_q.size(), 12);
    chk("pp_first0", (obs_q.size() > 1) ? obs_q[0] : 8'hxx, 8'h30);
    chk("pp_first1", (obs_q.size() > 1) ? obs_q[1] : 8'hxx, 8'h31);
    for (int i = 0; i < 10; i++)
      chk("pp_order", (i + 2 < obs_q.size()) ? obs_q[i + 2] : 8'hxx, 8'h61 + 8'(i));

    // Counter saturation and clear priority
    pulse_clr();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) send(8'h41 + 8'(i));
    drain();
    chk("sat_char_count", char_count, 15);
    chk("sat_conv_count", conv_count, 15);
    clr_cnt  = 1'b1;
    in_valid = 1'b1;
    in_char  = 8'h4D;
    @(posedge clk);
    #1;
    clr_cnt  = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("clr_char_count", char_count, 0);
    chk("clr_conv_count", conv_count, 0);
    chk("clr_keeps_data", out_char, 8'h6D);
    drain();

    // Reset mid-operation at occupancy 3
    out_ready = 1'b0;
    send(8'h41);
    send(8'h42);
    send(8'h43);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_char", out_char, 8'h00);
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_char_count", char_count, 0);
    chk("mrst_conv_count", conv_count, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    obs_q.delete();
    out_ready = 1'b1;
    send(8'h51);
    drain();
    chk("mrst_obs_count", obs_q.size(), 1);
    chk("mrst_first_out", (obs_q.size() > 0) ? obs_q[0] : 8'hxx, 8'h71);

    // Random stress against the queue model
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_char   = 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 2) != 0);
      clr_cnt   = ($urandom_range(0, 63) == 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
    drain();
    chk("stress_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
